// File: rtl/bist_seq_ctrl.sv
`default_nettype none
// bist_seq_ctrl -- BIST sequencer: core flush, LFSR vector apply, MISR compaction to a 32-bit signature.
// Rev 1.0 -- optional macro BIST_SEQ_CMP_EN adds sig_exp comparison with pass/fail flags.
module bist_seq_ctrl #(
  parameter int          IN_W      = 19,
  parameter int          OUT_W     = 19,
  parameter int          CLR_BIT   = 18,
  parameter int          FLUSH_CYC = 2,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  parameter logic [31:0] MISR_SEED = 32'h0000_0000
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig,
  output logic             sig_vld
`ifdef BIST_SEQ_CMP_EN
  ,
  input  logic [31:0]      sig_exp,
  output logic             pass,
  output logic             fail
`endif
);

  localparam logic [31:0]     c_poly       = 32'h8040_0003;
  localparam int              FC_W         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] c_flush_last = FC_W'(FLUSH_CYC - 1);
  localparam logic [IN_W-1:0] c_clr_vec    = IN_W'(1) << CLR_BIT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_lfsr;
  logic [31:0]      r_misr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nvec;
  logic [FC_W-1:0]  r_fcnt;
  logic [IN_W-1:0]  r_core_in;
  logic             r_busy;
  logic             r_done;
  logic             r_sig_vld;

  logic [31:0] w_lfsr_nxt;
  logic [31:0] w_misr_nxt;
  logic        w_accept;
  logic        w_flush_end;
  logic        w_apply_end;
  logic        w_to_done;

  function automatic logic [31:0] f_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? c_poly : 32'h0);
  endfunction

  // Vector view of the LFSR with the core's clear line held inactive.
  function automatic logic [IN_W-1:0] f_vec(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] v;
    v          = x;
    v[CLR_BIT] = 1'b0;
    return v;
  endfunction

  assign w_lfsr_nxt  = f_step(r_lfsr);
  assign w_misr_nxt  = f_step(r_misr ^ 32'(core_out));
  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  assign w_flush_end = (r_state == S_FLUSH) && (r_fcnt == c_flush_last);
  assign w_apply_end = (r_state == S_APPLY) && (r_cnt == r_nvec - 1'b1);
  assign w_to_done   = !abort && ((w_flush_end && (r_nvec == '0)) || w_apply_end);

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_misr    <= MISR_SEED;
      r_cnt     <= '0;
      r_nvec    <= '0;
      r_fcnt    <= '0;
      r_core_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sig_vld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_core_in <= '0;
        r_sig_vld <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_nvec    <= num_vec;
              r_lfsr    <= LFSR_SEED;
              r_misr    <= MISR_SEED;
              r_sig_vld <= 1'b0;
              r_fcnt    <= '0;
              r_busy    <= 1'b1;
              r_core_in <= c_clr_vec;
              r_state   <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            r_fcnt <= r_fcnt + 1'b1;
            if (w_flush_end && (r_nvec != '0)) begin
              r_state   <= S_APPLY;
              r_cnt     <= '0;
              r_core_in <= f_vec(r_lfsr[IN_W-1:0]);
            end
          end
          S_APPLY: begin
            r_misr    <= w_misr_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_cnt     <= r_cnt + 1'b1;
            r_core_in <= f_vec(w_lfsr_nxt[IN_W-1:0]);
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
        // Completion overrides the per-state updates of core_in/state above.
        if (w_to_done) begin
          r_state   <= S_DONE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_sig_vld <= 1'b1;
          r_core_in <= '0;
        end
      end
    end
  end

  assign core_in = r_core_in;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sig     = r_misr;
  assign sig_vld = r_sig_vld;

`ifdef BIST_SEQ_CMP_EN
  logic [31:0] w_final;
  logic        r_pass;
  logic        r_fail;

  // Signature as it will read once DONE is entered.
  assign w_final = (r_state == S_APPLY) ? w_misr_nxt : r_misr;

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (abort || w_accept) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_to_done) begin
      r_pass <= (w_final == sig_exp);
      r_fail <= (w_final != sig_exp);
    end
  end

  assign pass = r_pass;
  assign fail = r_fail;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bist_seq_ctrl.sv
`default_nettype none
// tb_bist_seq_ctrl -- scoreboard bench with a behavioural core and a high-level signature model.
module tb_bist_seq_ctrl;
  localparam logic [31:0] C_MASK  = 32'h8040_0003;
  localparam logic [31:0] C_LSEED = 32'hACE1_0001;
  localparam int          C_FLUSH = 2;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_vec = 16'd0;
  logic [18:0] core_in;
  logic [18:0] core_out;
  logic        busy, done, sig_vld;
  logic [31:0] sig;
`ifdef BIST_SEQ_CMP_EN
  logic [31:0] sig_exp = 32'h0;
  logic        pass, fail;
`endif

  bist_seq_ctrl dut (
    .CK(CK), .RN(RN), .start(start), .abort(abort), .num_vec(num_vec),
    .core_in(core_in), .core_out(core_out), .busy(busy), .done(done),
    .sig(sig), .sig_vld(sig_vld)
`ifdef BIST_SEQ_CMP_EN
    , .sig_exp(sig_exp), .pass(pass), .fail(fail)
`endif
  );

  always #5 CK = ~CK;

  int          n_tot = 0;
  int          n_pass = 0;
  int          n_done = 0;
  bit          mon_en = 1'b0;
  bit          tie0 = 1'b0;
  logic [31:0] r_last_sig = 32'h0;
  logic [18:0] q_in[$];
  logic [31:0] q_sig[$];

  // Behavioural benchmark core: sync clear on bit 18, combinational output.
  function automatic logic [18:0] core_f(input logic [18:0] s, input logic [18:0] i);
    return s ^ {i[9:0], i[18:10]} ^ 19'h15A5A;
  endfunction
  function automatic logic [18:0] core_nx(input logic [18:0] s, input logic [18:0] i);
    return i[18] ? 19'h0 : ({s[17:0], s[18] ^ s[5]} ^ i);
  endfunction

  logic [18:0] r_core_st = 19'h0;
  assign core_out = tie0 ? 19'h0 : core_f(r_core_st, core_in);
  always @(posedge CK) r_core_st <= core_nx(r_core_st, core_in);

  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? C_MASK : 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Expected stimulus stream and signature for one run; abort_k in [0,n) cuts APPLY short.
  task automatic model_run(input int n, input int abort_k, input bit z, output logic [31:0] sig_o);
    logic [31:0] l;
    logic [31:0] m;
    logic [18:0] s;
    logic [18:0] v;
    l = C_LSEED;
    m = 32'h0;
    s = 19'h0;
    for (int f = 0; f < C_FLUSH; f++) q_in.push_back(19'h40000);
    for (int i = 0; i < n; i++) begin
      if (abort_k >= 0 && abort_k < n && i > abort_k) break;
      v = l[18:0];
      v[18] = 1'b0;
      q_in.push_back(v);
      m = step(m ^ {13'h0, (z ? 19'h0 : core_f(s, v))});
      s = core_nx(s, v);
      l = step(l);
    end
    sig_o = m;
    if (abort_k < 0 || abort_k >= n) q_sig.push_back(m);
  endtask

  always @(negedge CK) begin
    if (mon_en) begin
      if (busy) begin
        if (q_in.size() == 0) chk("unexpected_busy", 32'h1, 32'h0);
        else chk("core_in", {13'h0, core_in}, {13'h0, q_in.pop_front()});
      end else begin
        chk("core_in_idle", {13'h0, core_in}, 32'h0);
      end
      if (done) begin
        n_done++;
        r_last_sig = sig;
        if (q_sig.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
        else chk("sig", sig, q_sig.pop_front());
        chk("sig_vld_at_done", {31'h0, sig_vld}, 32'h1);
      end
    end
  end

  // abort_k: abort in cycle 3+abort_k after start (APPLY index, or DONE when == n).
  task automatic run(input int n, input int abort_k, input bit z, input bit start_mid, input bit flip);
    logic [31:0] m;
    bit          fin;
    model_run(n, abort_k, z, m);
`ifdef BIST_SEQ_CMP_EN
    sig_exp = m ^ {31'h0, flip};
`endif
    tie0    = z;
    num_vec = 16'(n);
    start   = 1'b1;
    fin     = 1'b0;
    for (int e = 1; e <= n + 40 && !fin; e++) begin
      @(posedge CK); #1;
      if (e == 1) begin
        start   = 1'b0;
        num_vec = 16'($urandom);
      end
      if (start_mid && e == 3) start = 1'b1;
      else if (start_mid && e == 4) start = 1'b0;
      if (abort_k >= 0 && e == 3 + abort_k) begin
        abort = 1'b1;
        @(posedge CK); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_sig_vld", {31'h0, sig_vld}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        fin = 1'b1;
      end else if (done) begin
        chk("latency_cycles", 32'(e + 1), 32'(n + C_FLUSH + 2));
        @(posedge CK); #1;
        start = 1'b0;
        chk("sig_vld_hold", {31'h0, sig_vld}, 32'h1);
        chk("idle_after_done", {31'h0, busy}, 32'h0);
`ifdef BIST_SEQ_CMP_EN
        chk("pass", {31'h0, pass}, {31'h0, ~flip});
        chk("fail", {31'h0, fail}, {31'h0, flip});
`endif
        fin = 1'b1;
      end
    end
    if (!fin) chk("run_timeout", 32'h0, 32'h1);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    logic [31:0] s1;
    int          n;
    int          k;
    RN      = 1'b0;
    start   = 1'b1;
    num_vec = 16'd5;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_core_in", {13'h0, core_in}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_sig_vld", {31'h0, sig_vld}, 32'h0);
    chk("rst_sig", sig, 32'h0);
    RN     = 1'b1;
    start  = 1'b0;
    mon_en = 1'b1;
    @(posedge CK); #1;
    chk("idle_after_reset", {31'h0, busy}, 32'h0);

    run(0, -1, 1'b0, 1'b0, 1'b0);
    d0 = n_done;
    run(3, -1, 1'b1, 1'b0, 1'b0);
    chk("done_once", 32'(n_done - d0), 32'h1);

    run(100, -1, 1'b0, 1'b0, 1'b0);
    s1 = r_last_sig;
    run(100, -1, 1'b0, 1'b0, 1'b1);
    chk("determinism", r_last_sig, s1);

    run(20, 4, 1'b0, 1'b0, 1'b0);
    run(20, -1, 1'b0, 1'b0, 1'b0);
    run(10, 10, 1'b0, 1'b0, 1'b0);
    run(15, -1, 1'b0, 1'b1, 1'b0);

    run(5, -1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    @(posedge CK); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle_busy", {31'h0, busy}, 32'h0);
    chk("abort_idle_sig_vld", {31'h0, sig_vld}, 32'h0);
    repeat (3) @(posedge CK);
    #1;
    chk("abort_start_no_run", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(1, 40));
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
      run(n, k, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge CK);
    #1;
    chk("q_in_drained", 32'(q_in.size()), 32'h0);
    chk("q_sig_drained", 32'(q_sig.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
